trng_ctrl: RTL and testbench

TRNG_CTRL -- requirements
Module: trng_ctrl

---
 rtl/trng_ctrl.sv | 170 +++++++++++++++++
 tb/tb_trng_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - ring-oscillator TRNG sampling controller with word handshake
// Optional repetition-count health test enabled by macro TRNG_HEALTH_TEST_EN.
module trng_ctrl #(
    parameter int WORD_W        = 32,
    parameter int WARMUP_CYCLES = 256,
    parameter int SAMPLE_DIV    = 8,
    parameter int RCT_LIMIT     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              raw_bit,
    output logic              trng_en,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              health_fail
);

    localparam int WCW = $clog2(WARMUP_CYCLES + 1);
    localparam int DVW = $clog2(SAMPLE_DIV + 1);
    localparam int BCW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        SAMPLE,
        HOLD,
        FAIL
    } state_t;

    state_t state, state_next;

    logic              sync1, sync2;
    logic [WCW-1:0]    warm_cnt;
    logic [DVW-1:0]    div_cnt;
    logic [BCW-1:0]    bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic              word_done;
    logic              tick;
    logic              rct_hit;

    assign word_done = (bit_cnt == BCW'(WORD_W));
    assign tick      = (state == SAMPLE) && !word_done && (div_cnt == DVW'(SAMPLE_DIV - 1));
    assign busy      = (state != IDLE);

`ifdef TRNG_HEALTH_TEST_EN
    logic [7:0] rep_cnt;
    logic       last_bit;

    // rep_cnt == 0 means no bit seen yet this session; it carries across words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt  <= 8'd0;
            last_bit <= 1'b0;
        end else if (state == IDLE) begin
            rep_cnt  <= 8'd0;
            last_bit <= 1'b0;
        end else if (tick) begin
            last_bit <= sync2;
            if (rep_cnt != 8'd0 && sync2 == last_bit) begin
                if (rep_cnt != 8'hFF) begin
                    rep_cnt <= rep_cnt + 8'd1;
                end
            end else begin
                rep_cnt <= 8'd1;
            end
        end
    end

    assign rct_hit     = (rep_cnt >= 8'(RCT_LIMIT));
    assign health_fail = (state == FAIL);
`else
    assign rct_hit     = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = WARMUP;
            end
            WARMUP: begin
                if (!start)                                 state_next = IDLE;
                else if (warm_cnt == WCW'(WARMUP_CYCLES - 1)) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (rct_hit)        state_next = FAIL;
                else if (!start)    state_next = IDLE;
                else if (word_done) state_next = HOLD;
            end
            HOLD: begin
                if (word_ready) state_next = start ? SAMPLE : IDLE;
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Enable and valid are registered from the next state so they change with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            trng_en    <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            warm_cnt   <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            sync1      <= raw_bit;
            sync2      <= sync1;
            trng_en    <= (state_next == WARMUP) || (state_next == SAMPLE) || (state_next == HOLD);
            word_valid <= (state_next == HOLD);
            case (state)
                IDLE: begin
                    warm_cnt <= '0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                end
                WARMUP: begin
                    warm_cnt <= warm_cnt + WCW'(1);
                end
                SAMPLE: begin
                    if (word_done) begin
                        if (state_next == HOLD) begin
                            word_data <= shreg;
                        end
                        bit_cnt <= '0;
                        div_cnt <= '0;
                    end else if (tick) begin
                        div_cnt <= '0;
                        shreg   <= {shreg[WORD_W-2:0], sync2};
                        bit_cnt <= bit_cnt + BCW'(1);
                    end else begin
                        div_cnt <= div_cnt + DVW'(1);
                    end
                end
                HOLD: begin
                    div_cnt <= '0;
                end
                FAIL: begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                end
                default: begin
                    div_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trng_ctrl.sv
// tb/tb_trng_ctrl.sv - directed vector bench for trng_ctrl (WORD_W=8, WARMUP=4, DIV=2, RCT=5)
module tb_trng_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       raw_bit;
    logic       trng_en;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       busy;
    logic       health_fail;

    trng_ctrl #(
        .WORD_W(8),
        .WARMUP_CYCLES(4),
        .SAMPLE_DIV(2),
        .RCT_LIMIT(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .raw_bit(raw_bit),
        .trng_en(trng_en),
        .word_data(word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy(busy),
        .health_fail(health_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    logic sched [0:127];

    typedef struct {
        logic [7:0] pat;
        logic [7:0] exp;
        string      tag;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // cyc counts edges after the one that samples start; sched[n] is driven just after edge n.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= 0 && cyc < 128) raw_bit = sched[cyc];
    endtask

    task automatic clear_sched(input logic v);
        for (int i = 0; i < 128; i++) sched[i] = v;
    endtask

    // Sampling starts after edge b; tick i lands on edge b+2i and sees raw_bit from edge b+2i-2.
    task automatic fill_sched(input logic [7:0] p, input int b);
        for (int i = 1; i <= 8; i++) begin
            sched[b - 3 + 2 * i] = p[8 - i];
            sched[b - 2 + 2 * i] = p[8 - i];
        end
    endtask

    task automatic run_session(input logic [7:0] pat, input logic [7:0] exp, input string tag);
        clear_sched(1'b0);
        fill_sched(pat, 4);
        cyc   = -1;
        start = 1'b1;
        step();
        check({tag, "_en"}, 64'(trng_en), 64'd1);
        repeat (19) step();
        step();
        check({tag, "_valid_early"}, 64'(word_valid), 64'd0);
        step();
        check({tag, "_valid_21"}, 64'(word_valid), 64'd1);
        check({tag, "_data"}, 64'(word_data), 64'(exp));
        word_ready = 1'b1;
        start      = 1'b0;
        step();
        check({tag, "_valid_drop"}, 64'(word_valid), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_en"}, 64'(trng_en), 64'd0);
        word_ready = 1'b0;
    endtask

    initial begin
        logic ok;

        vecs[0] = '{pat: 8'h5A, exp: 8'h5A, tag: "v5a"};
        vecs[1] = '{pat: 8'hC6, exp: 8'hC6, tag: "vc6"};
        vecs[2] = '{pat: 8'h69, exp: 8'h69, tag: "v69"};
        vecs[3] = '{pat: 8'h33, exp: 8'h33, tag: "v33"};

        rst_n      = 1'b0;
        start      = 1'b1;
        word_ready = 1'b1;
        raw_bit    = 1'b0;
        cyc        = -100;
        clear_sched(1'b0);

        // Reset with start held, then two back-to-back words with ready high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 64'(trng_en), 64'd0);
        check("rst_valid", 64'(word_valid), 64'd0);
        check("rst_data", 64'(word_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_health", 64'(health_fail), 64'd0);
        fill_sched(8'hB2, 4);
        fill_sched(8'h5A, 22);
        cyc   = -1;
        rst_n = 1'b1;
        step();
        check("first_en", 64'(trng_en), 64'd1);
        check("first_busy", 64'(busy), 64'd1);
        repeat (19) step();
        step();
        check("w1_valid_early", 64'(word_valid), 64'd0);
        step();
        check("w1_valid_21", 64'(word_valid), 64'd1);
        check("w1_data_b2", 64'(word_data), 64'h00B2);
        step();
        check("w1_valid_one_cycle", 64'(word_valid), 64'd0);
        check("w1_en_kept", 64'(trng_en), 64'd1);
        repeat (15) step();
        step();
        check("w2_valid_early", 64'(word_valid), 64'd0);
        word_ready = 1'b0;
        step();
        check("w2_valid_no_warmup", 64'(word_valid), 64'd1);
        check("w2_data_5a", 64'(word_data), 64'h005A);

        // Back-pressure in HOLD for 30 cycles with raw_bit toggling.
        ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            raw_bit = 1'(k & 1);
            if (word_valid !== 1'b1 || word_data !== 8'h5A || trng_en !== 1'b1) ok = 1'b0;
        end
        check("hold_stable", 64'(ok), 64'd1);
        word_ready = 1'b1;
        step();
        check("hold_release_valid", 64'(word_valid), 64'd0);
        check("hold_release_en", 64'(trng_en), 64'd1);
        start      = 1'b0;
        word_ready = 1'b0;
        step();
        check("sample_abort_busy", 64'(busy), 64'd0);

        // Abort after three ticks, then the table sessions each restart from IDLE.
        clear_sched(1'b1);
        cyc   = -1;
        start = 1'b1;
        repeat (11) step();
        check("abort_busy_before", 64'(busy), 64'd1);
        start = 1'b0;
        step();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_en", 64'(trng_en), 64'd0);
        check("abort_valid", 64'(word_valid), 64'd0);

        for (int v = 0; v < 4; v++) begin
            run_session(vecs[v].pat, vecs[v].exp, vecs[v].tag);
        end

`ifdef TRNG_HEALTH_TEST_EN
        raw_bit = 1'b1;
        clear_sched(1'b1);
        cyc   = -1;
        start = 1'b1;
        repeat (15) step();
        check("rct_before_5th", 64'(health_fail), 64'd0);
        step();
        check("rct_health", 64'(health_fail), 64'd1);
        check("rct_en", 64'(trng_en), 64'd0);
        check("rct_busy", 64'(busy), 64'd1);
        ok = 1'b1;
        repeat (15) begin
            step();
            if (word_valid !== 1'b0 || health_fail !== 1'b1 || trng_en !== 1'b0) ok = 1'b0;
        end
        check("rct_sticky", 64'(ok), 64'd1);
        start = 1'b0;
        repeat (3) step();
        check("rct_sticky_nostart", 64'(health_fail), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rct_reset_clear", 64'(health_fail), 64'd0);
        check("rct_reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        raw_bit = 1'b1;
        run_session(8'hFF, 8'hFF, "stuck1");
        check("stuck1_health", 64'(health_fail), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
